wb_master_arbiter: RTL and testbench

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

---
 rtl/wb_master_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_arbiter.sv
// Two-requester Wishbone classic master with alternating arbitration and a per-transfer bus timeout.
// Latency: a start sampled at edge T raises wb_cyc_o after edge T+1 when the bus is idle; two cyc-low cycles separate transfers.
// Backpressure: one outstanding request per requester; a start is dropped while that requester's reqN_active is high.
// Ports: req0_*/req1_* carry each requester's request and result; wb_*_o drive the Wishbone master request; wb_*_i are the slave response.
module wb_master_arbiter #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          req0_start,
    input  logic [aw-1:0] req0_address,
    input  logic [3:0]    req0_selection,
    input  logic          req0_write,
    input  logic [dw-1:0] req0_data_wr,
    output logic [dw-1:0] req0_data_rd,
    output logic          req0_active,
    output logic          req0_error,
    input  logic          req1_start,
    input  logic [aw-1:0] req1_address,
    input  logic [3:0]    req1_selection,
    input  logic          req1_write,
    input  logic [dw-1:0] req1_data_wr,
    output logic [dw-1:0] req1_data_rd,
    output logic          req1_active,
    output logic          req1_error,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [7:0] TMO    = 8'(TIMEOUT);

    // Per-requester views of the request ports so both sides share one code path.
    logic          start  [2];
    logic [aw-1:0] in_adr [2];
    logic [3:0]    in_sel [2];
    logic          in_we  [2];
    logic [dw-1:0] in_dat [2];

    assign start[0]  = req0_start;
    assign start[1]  = req1_start;
    assign in_adr[0] = req0_address;
    assign in_adr[1] = req1_address;
    assign in_sel[0] = req0_selection;
    assign in_sel[1] = req1_selection;
    assign in_we[0]  = req0_write;
    assign in_we[1]  = req1_write;
    assign in_dat[0] = req0_data_wr;
    assign in_dat[1] = req1_data_wr;

    logic [1:0]    state_q, state_d;
    logic [1:0]    pending_q, pending_d;
    logic          last_grant_q, last_grant_d;
    logic          gnt_q, gnt_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [aw-1:0] hold_adr_q [2];
    logic [aw-1:0] hold_adr_d [2];
    logic [3:0]    hold_sel_q [2];
    logic [3:0]    hold_sel_d [2];
    logic [1:0]    hold_we_q, hold_we_d;
    logic [dw-1:0] hold_dat_q [2];
    logic [dw-1:0] hold_dat_d [2];
    logic [dw-1:0] data_rd_q [2];
    logic [dw-1:0] data_rd_d [2];
    logic [1:0]    error_q, error_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [aw-1:0] adr_q, adr_d;
    logic [dw-1:0] dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          pick;
    logic [7:0]    cnt_inc;

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        hold_we_d    = hold_we_q;
        error_d      = error_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        // On a tie the requester not served last wins; otherwise the single pending one.
        pick         = (pending_q == 2'b11) ? ~last_grant_q : pending_q[1];
        cnt_inc      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

        for (int n = 0; n < 2; n++) begin
            hold_adr_d[n] = hold_adr_q[n];
            hold_sel_d[n] = hold_sel_q[n];
            hold_dat_d[n] = hold_dat_q[n];
            data_rd_d[n]  = data_rd_q[n];
            // pending doubles as the active flag, so starts during a transfer
            // (including its completion edge) are dropped here.
            if (start[n] && !pending_q[n]) begin
                hold_adr_d[n] = in_adr[n];
                hold_sel_d[n] = in_sel[n];
                hold_we_d[n]  = in_we[n];
                hold_dat_d[n] = in_dat[n];
                pending_d[n]  = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pending_q != 2'b00) begin
                    gnt_d        = pick;
                    last_grant_d = pick;
                    cyc_d        = 1'b1;
                    adr_d        = hold_adr_q[pick];
                    dat_d        = hold_dat_q[pick];
                    sel_d        = hold_sel_q[pick];
                    we_d         = hold_we_q[pick];
                    cnt_d        = 8'd0;
                    state_d      = S_BUS;
                end
            end
            S_BUS: begin
                cnt_d = cnt_inc;
                if (wb_err_i || wb_ack_i || (cnt_inc == TMO)) begin
                    cyc_d            = 1'b0;
                    pending_d[gnt_q] = 1'b0;
                    state_d          = S_DONE;
                    // err beats ack; no ack and no err here means the timeout fired.
                    if (wb_err_i || !wb_ack_i) begin
                        error_d[gnt_q]   = 1'b1;
                        data_rd_d[gnt_q] = '0;
                    end else begin
                        error_d[gnt_q] = 1'b0;
                        if (!we_q) begin
                            data_rd_d[gnt_q] = wb_dat_i;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q      <= S_IDLE;
            pending_q    <= 2'b00;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            cnt_q        <= 8'd0;
            hold_we_q    <= 2'b00;
            error_q      <= 2'b00;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= 4'd0;
            for (int n = 0; n < 2; n++) begin
                hold_adr_q[n] <= '0;
                hold_sel_q[n] <= 4'd0;
                hold_dat_q[n] <= '0;
                data_rd_q[n]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            hold_we_q    <= hold_we_d;
            error_q      <= error_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            for (int n = 0; n < 2; n++) begin
                hold_adr_q[n] <= hold_adr_d[n];
                hold_sel_q[n] <= hold_sel_d[n];
                hold_dat_q[n] <= hold_dat_d[n];
                data_rd_q[n]  <= data_rd_d[n];
            end
        end
    end

    assign req0_data_rd = data_rd_q[0];
    assign req1_data_rd = data_rd_q[1];
    assign req0_active  = pending_q[0];
    assign req1_active  = pending_q[1];
    assign req0_error   = error_q[0];
    assign req1_error   = error_q[1];
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;
    assign wb_we_o      = we_q;
    assign wb_cyc_o     = cyc_q;
    // stb follows cyc exactly, so it can never be high on its own.
    assign wb_stb_o     = cyc_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
module tb_wb_master_arbiter;

    logic        wb_clk;
    logic        wb_rst;
    logic        req0_start, req1_start;
    logic [31:0] req0_address, req1_address;
    logic [3:0]  req0_selection, req1_selection;
    logic        req0_write, req1_write;
    logic [31:0] req0_data_wr, req1_data_wr;
    logic [31:0] req0_data_rd, req1_data_rd;
    logic        req0_active, req1_active;
    logic        req0_error, req1_error;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    wb_master_arbiter #(.dw(32), .aw(32), .TIMEOUT(8)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .req0_start(req0_start), .req0_address(req0_address), .req0_selection(req0_selection),
        .req0_write(req0_write), .req0_data_wr(req0_data_wr), .req0_data_rd(req0_data_rd),
        .req0_active(req0_active), .req0_error(req0_error),
        .req1_start(req1_start), .req1_address(req1_address), .req1_selection(req1_selection),
        .req1_write(req1_write), .req1_data_wr(req1_data_wr), .req1_data_rd(req1_data_rd),
        .req1_active(req1_active), .req1_error(req1_error),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slave model: mode 0 ack, 1 never responds, 2 ack+err together, 3 err only.
    int          slv_mode = 0;
    int          slv_dly  = 1;
    int          slv_age  = 0;
    logic [31:0] slv_rdat = 32'h0;
    assign wb_dat_i = slv_rdat;

    always @(posedge wb_clk) begin
        #1;
        if (wb_cyc_o && wb_stb_o) begin
            slv_age = slv_age + 1;
            if (slv_age == slv_dly) begin
                wb_ack_i = (slv_mode == 0 || slv_mode == 2);
                wb_err_i = (slv_mode == 2 || slv_mode == 3);
            end
        end else begin
            slv_age  = 0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end
    end

    // Scoreboards: expected bus requests in grant order, expected completions in order.
    typedef struct { logic [31:0] adr; logic [3:0] sel; logic we; logic [31:0] dat; } gnt_t;
    typedef struct { bit n; logic [31:0] rd; logic err; } cpl_t;
    gnt_t gq[$];
    cpl_t cq[$];

    function automatic logic [31:0] rd_of(input bit n);
        return n ? req1_data_rd : req0_data_rd;
    endfunction
    function automatic logic err_of(input bit n);
        return n ? req1_error : req0_error;
    endfunction
    function automatic logic act_of(input bit n);
        return n ? req1_active : req0_active;
    endfunction

    logic        prev_cyc = 1'b0;
    logic [1:0]  prev_act = 2'b00;
    logic [31:0] prev_adr, prev_dat;
    logic [3:0]  prev_sel;
    logic        prev_we;

    always @(negedge wb_clk) begin
        if (wb_rst) begin
            prev_cyc = 1'b0;
            prev_act = 2'b00;
        end else begin
            chk("stb_without_cyc", {31'd0, wb_stb_o & ~wb_cyc_o}, 32'd0);
            if (wb_cyc_o && !prev_cyc) begin
                chk("grant_expected", {31'd0, gq.size() != 0}, 32'd1);
                if (gq.size() != 0) begin
                    gnt_t g;
                    g = gq.pop_front();
                    chk("grant_adr", wb_adr_o, g.adr);
                    chk("grant_dat", wb_dat_o, g.dat);
                    chk("grant_sel", {28'd0, wb_sel_o}, {28'd0, g.sel});
                    chk("grant_we", {31'd0, wb_we_o}, {31'd0, g.we});
                end
            end
            if (wb_cyc_o && prev_cyc) begin
                chk("bus_stable", {wb_adr_o ^ prev_adr} | {wb_dat_o ^ prev_dat}
                    | {28'd0, wb_sel_o ^ prev_sel} | {31'd0, wb_we_o ^ prev_we}, 32'd0);
            end
            for (int n = 0; n < 2; n++) begin
                if (prev_act[n] && !act_of(n[0])) begin
                    chk("completion_expected", {31'd0, cq.size() != 0}, 32'd1);
                    if (cq.size() != 0) begin
                        cpl_t c;
                        c = cq.pop_front();
                        chk("cpl_requester", n, {31'd0, c.n});
                        chk("cpl_data_rd", rd_of(n[0]), c.rd);
                        chk("cpl_error", {31'd0, err_of(n[0])}, {31'd0, c.err});
                    end
                end
            end
            prev_cyc = wb_cyc_o;
            prev_act = {req1_active, req0_active};
        end
        prev_adr = wb_adr_o;
        prev_dat = wb_dat_o;
        prev_sel = wb_sel_o;
        prev_we  = wb_we_o;
    end

    task automatic tick();
        @(posedge wb_clk);
        #2;
    endtask

    task automatic drive_req(input bit n, input bit we, input logic [31:0] adr,
                             input logic [3:0] sel, input logic [31:0] dat);
        if (!n) begin
            req0_start = 1'b1; req0_write = we; req0_address = adr;
            req0_selection = sel; req0_data_wr = dat;
        end else begin
            req1_start = 1'b1; req1_write = we; req1_address = adr;
            req1_selection = sel; req1_data_wr = dat;
        end
    endtask

    task automatic push_exp(input bit n, input bit we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input logic [31:0] rd, input logic err);
        gq.push_back('{adr: adr, sel: sel, we: we, dat: dat});
        cq.push_back('{n: n, rd: rd, err: err});
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while ((req0_active || req1_active || wb_cyc_o) && k < 300) begin
            tick();
            k++;
        end
        chk(nm, {29'd0, req0_active, req1_active, wb_cyc_o}, 32'd0);
    endtask

    typedef struct {
        bit n; bit we; logic [31:0] adr; logic [3:0] sel; logic [31:0] wdat;
        int mode; int dly; logic [31:0] rdat;
        logic [31:0] exp_rd; logic exp_err; int exp_cyc;
    } vec_t;
    vec_t vt[7];

    initial begin
        int k, gap, c0, c1;

        vt[0] = '{1'b1, 1'b0, 32'h20, 4'hF, 32'h0,        0, 1, 32'h12345678, 32'h12345678, 1'b0, 1};
        vt[1] = '{1'b0, 1'b1, 32'h30, 4'h3, 32'hCAFEF00D, 0, 2, 32'h99999999, 32'hDEADBEEF, 1'b0, 2};
        vt[2] = '{1'b1, 1'b1, 32'h40, 4'hC, 32'h0BADC0DE, 0, 3, 32'h88888888, 32'h12345678, 1'b0, 3};
        vt[3] = '{1'b0, 1'b0, 32'h50, 4'hF, 32'h0,        3, 2, 32'h77777777, 32'h0,        1'b1, 2};
        vt[4] = '{1'b0, 1'b0, 32'h54, 4'h1, 32'h0,        0, 2, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 2};
        vt[5] = '{1'b1, 1'b0, 32'h60, 4'hF, 32'h0,        1, 1, 32'h66666666, 32'h0,        1'b1, 8};
        vt[6] = '{1'b1, 1'b0, 32'h64, 4'hF, 32'h0,        0, 1, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, 1};

        req0_start = 0; req0_address = 0; req0_selection = 0; req0_write = 0; req0_data_wr = 0;
        req1_start = 0; req1_address = 0; req1_selection = 0; req1_write = 0; req1_data_wr = 0;
        wb_rst = 1'b1;
        tick();
        tick();
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_bus", wb_adr_o | wb_dat_o | {28'd0, wb_sel_o} | {31'd0, wb_we_o}, 32'd0);
        chk("rst_active", {30'd0, req1_active, req0_active}, 32'd0);
        chk("rst_error", {30'd0, req1_error, req0_error}, 32'd0);
        chk("rst_data_rd", req0_data_rd | req1_data_rd, 32'd0);
        wb_rst = 1'b0;
        tick();

        // Single read, slave acks on the third stb cycle.
        slv_mode = 0; slv_dly = 3; slv_rdat = 32'hDEADBEEF;
        push_exp(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
        drive_req(1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
        tick();
        req0_start = 1'b0;
        chk("t1_active_after_start", {31'd0, req0_active}, 32'd1);
        chk("t1_cyc_after_T", {31'd0, wb_cyc_o}, 32'd0);
        tick();
        chk("t1_cyc_after_T1", {31'd0, wb_cyc_o}, 32'd1);
        chk("t1_stb_after_T1", {31'd0, wb_stb_o}, 32'd1);
        k = 0;
        while (wb_cyc_o && k < 20) begin
            tick();
            k++;
        end
        chk("t1_cyc_cycles", k, 32'd3);
        chk("t1_data_rd", req0_data_rd, 32'hDEADBEEF);
        chk("t1_error", {31'd0, req0_error}, 32'd0);
        chk("t1_active_low", {31'd0, req0_active}, 32'd0);
        tick();

        // Table of single transfers: reads, writes, err, timeout and recovery.
        for (int i = 0; i < 7; i++) begin
            int lat, ncyc;
            slv_mode = vt[i].mode; slv_dly = vt[i].dly; slv_rdat = vt[i].rdat;
            push_exp(vt[i].n, vt[i].we, vt[i].adr, vt[i].sel, vt[i].wdat, vt[i].exp_rd, vt[i].exp_err);
            drive_req(vt[i].n, vt[i].we, vt[i].adr, vt[i].sel, vt[i].wdat);
            tick();
            req0_start = 1'b0; req1_start = 1'b0;
            lat = 0;
            while (!wb_cyc_o && lat < 10) begin
                tick();
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), lat, 32'd1);
            ncyc = 0;
            while (wb_cyc_o && ncyc < 300) begin
                tick();
                ncyc++;
            end
            chk($sformatf("vec%0d_cyc_cycles", i), ncyc, vt[i].exp_cyc);
            chk($sformatf("vec%0d_data_rd", i), rd_of(vt[i].n), vt[i].exp_rd);
            chk($sformatf("vec%0d_error", i), {31'd0, err_of(vt[i].n)}, {31'd0, vt[i].exp_err});
            chk($sformatf("vec%0d_active", i), {31'd0, act_of(vt[i].n)}, 32'd0);
            tick();
        end

        // Both start together: req0 first, req1 after the two-cycle gap.
        slv_mode = 0; slv_dly = 2;
        push_exp(1'b0, 1'b1, 32'h100, 4'hF, 32'h11111111, 32'hA5A5A5A5, 1'b0);
        push_exp(1'b1, 1'b1, 32'h200, 4'hF, 32'h22222222, 32'h0F0F0F0F, 1'b0);
        drive_req(1'b0, 1'b1, 32'h100, 4'hF, 32'h11111111);
        drive_req(1'b1, 1'b1, 32'h200, 4'hF, 32'h22222222);
        tick();
        req0_start = 1'b0; req1_start = 1'b0;
        chk("t3_both_active", {30'd0, req1_active, req0_active}, 32'd3);
        k = 0;
        while (!wb_cyc_o && k < 10) begin tick(); k++; end
        chk("t3_first_adr", wb_adr_o, 32'h100);
        k = 0;
        while (wb_cyc_o && k < 20) begin tick(); k++; end
        chk("t3_act_after_first", {30'd0, req1_active, req0_active}, 32'd2);
        gap = 0;
        while (!wb_cyc_o && gap < 10) begin tick(); gap++; end
        chk("t3_gap_cycles", gap, 32'd2);
        chk("t3_second_adr", wb_adr_o, 32'h200);
        wait_idle("t3_idle");
        tick();

        // Continuous restarts from both sides: grant order 0,1,0,1,0,1.
        slv_mode = 0; slv_dly = 1;
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b0, 1'b1, 32'h300 + 32'(i * 4), 4'hF, 32'h30300000 + 32'(i), 32'hA5A5A5A5, 1'b0);
            push_exp(1'b1, 1'b1, 32'h400 + 32'(i * 4), 4'hF, 32'h40400000 + 32'(i), 32'h0F0F0F0F, 1'b0);
        end
        c0 = 0; c1 = 0; k = 0;
        while (!(c0 == 3 && c1 == 3 && !req0_active && !req1_active) && k < 300) begin
            if (!req0_active && c0 < 3) begin
                drive_req(1'b0, 1'b1, 32'h300 + 32'(c0 * 4), 4'hF, 32'h30300000 + 32'(c0));
                c0++;
            end
            if (!req1_active && c1 < 3) begin
                drive_req(1'b1, 1'b1, 32'h400 + 32'(c1 * 4), 4'hF, 32'h40400000 + 32'(c1));
                c1++;
            end
            tick();
            req0_start = 1'b0; req1_start = 1'b0;
            k++;
        end
        chk("t4_all_issued", c0 + c1, 32'd6);
        wait_idle("t4_idle");
        tick();

        // ack+err together, plus a start landing on the completion edge.
        slv_mode = 2; slv_dly = 2; slv_rdat = 32'h55555555;
        push_exp(1'b0, 1'b0, 32'h500, 4'hF, 32'h0, 32'h0, 1'b1);
        drive_req(1'b0, 1'b0, 32'h500, 4'hF, 32'h0);
        tick();
        req0_start = 1'b0;
        k = 0;
        while (!wb_ack_i && k < 10) begin tick(); k++; end
        chk("t5_ack_seen", {31'd0, wb_ack_i & wb_err_i}, 32'd1);
        drive_req(1'b0, 1'b1, 32'h5FF, 4'hF, 32'h12121212);
        tick();
        req0_start = 1'b0;
        chk("t5_cyc_dropped", {31'd0, wb_cyc_o}, 32'd0);
        chk("t5_start_ignored", {31'd0, req0_active}, 32'd0);
        chk("t5_error", {31'd0, req0_error}, 32'd1);
        chk("t5_data_rd", req0_data_rd, 32'd0);
        repeat (4) tick();
        chk("t5_still_quiet", {30'd0, req0_active, wb_cyc_o}, 32'd0);

        // Reset in the middle of a transfer that would otherwise time out.
        slv_mode = 1;
        gq.push_back('{adr: 32'h600, sel: 4'hF, we: 1'b0, dat: 32'h0});
        drive_req(1'b0, 1'b0, 32'h600, 4'hF, 32'h0);
        tick();
        req0_start = 1'b0;
        k = 0;
        while (!wb_cyc_o && k < 10) begin tick(); k++; end
        tick();
        tick();
        chk("t6_cyc_before_rst", {31'd0, wb_cyc_o}, 32'd1);
        wb_rst = 1'b1;
        drive_req(1'b1, 1'b0, 32'h6FF, 4'hF, 32'h0);
        tick();
        wb_rst = 1'b0;
        req1_start = 1'b0;
        chk("t6_cyc_stb_after_rst", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("t6_active_after_rst", {30'd0, req1_active, req0_active}, 32'd0);
        chk("t6_error_after_rst", {30'd0, req1_error, req0_error}, 32'd0);
        tick();
        chk("t6_no_capture_in_rst", {30'd0, req1_active, wb_cyc_o}, 32'd0);
        slv_mode = 0; slv_dly = 1;
        push_exp(1'b0, 1'b1, 32'h700, 4'hF, 32'h70707070, 32'h0, 1'b0);
        push_exp(1'b1, 1'b1, 32'h710, 4'hF, 32'h71717171, 32'h0, 1'b0);
        drive_req(1'b0, 1'b1, 32'h700, 4'hF, 32'h70707070);
        drive_req(1'b1, 1'b1, 32'h710, 4'hF, 32'h71717171);
        tick();
        req0_start = 1'b0; req1_start = 1'b0;
        tick();
        chk("t6_tie_to_req0", wb_adr_o, 32'h700);
        wait_idle("t6_idle");
        tick();

        chk("grant_queue_drained", gq.size(), 32'd0);
        chk("cpl_queue_drained", cq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
